// File: rtl/led_pwm_dimmer.sv
// Per-channel PWM output stage with a global saturating brightness level.
// Define LED_PWM_FADE_EN to ramp each channel's duty toward its target instead of switching instantly.
module led_pwm_dimmer #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 4,
  parameter int FADE_DIV = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    led_in,
  input  logic                bright_up,
  input  logic                bright_down,
  output logic [WIDTH-1:0]    led_out,
  output logic [PWM_BITS-1:0] level
);

  localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CNT_LAST  = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] LEVEL_RST = {1'b1, {(PWM_BITS-1){1'b0}}};

  if (PWM_BITS < 2) begin : g_bad_pwm_bits
    $error("led_pwm_dimmer: PWM_BITS must be at least 2");
  end
  if (FADE_DIV < 1) begin : g_bad_fade_div
    $error("led_pwm_dimmer: FADE_DIV must be at least 1");
  end

  logic [WIDTH-1:0]    led_q_reg;
  logic [PWM_BITS-1:0] level_reg;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] cnt_reg;
  logic [PWM_BITS-1:0] cnt_next;
  logic [WIDTH-1:0]    led_out_reg;
  logic [WIDTH-1:0]    led_out_next;
  logic [PWM_BITS-1:0] tgt  [WIDTH];
  logic [PWM_BITS-1:0] duty [WIDTH];

  // Simultaneous up and down cancel; both directions saturate.
  always_comb begin
    level_next = level_reg;
    if (bright_up && !bright_down && (level_reg != MAX)) begin
      level_next = level_reg + 1'b1;
    end else if (bright_down && !bright_up && (level_reg != '0)) begin
      level_next = level_reg - 1'b1;
    end
  end

  // Period is MAX cycles so that duty MAX is steady-on and duty 0 steady-off.
  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q_reg   <= '0;
      level_reg   <= LEVEL_RST;
      cnt_reg     <= '0;
      led_out_reg <= '0;
    end else begin
      led_q_reg   <= led_in;
      level_reg   <= level_next;
      cnt_reg     <= cnt_next;
      led_out_reg <= led_out_next;
    end
  end

`ifdef LED_PWM_FADE_EN
  localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

  logic [PRE_W-1:0] pre_reg;
  logic             fade_step;

  // Free-running prescaler; target changes never restart it.
  assign fade_step = (pre_reg == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_reg <= '0;
    end else if (fade_step) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_reg + 1'b1;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      assign tgt[gi] = led_q_reg[gi] ? level_reg : '0;

`ifdef LED_PWM_FADE_EN
      logic [PWM_BITS-1:0] duty_reg;

      // One step toward the target per prescaler wrap; reversal starts from the current duty.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          duty_reg <= '0;
        end else if (fade_step) begin
          if (duty_reg < tgt[gi]) begin
            duty_reg <= duty_reg + 1'b1;
          end else if (duty_reg > tgt[gi]) begin
            duty_reg <= duty_reg - 1'b1;
          end
        end
      end

      assign duty[gi] = duty_reg;
`else
      assign duty[gi] = tgt[gi];
`endif

      // High run starts at cnt 0 and lasts exactly duty cycles.
      assign led_out_next[gi] = (duty[gi] > cnt_reg);
    end
  endgenerate

  assign led_out = led_out_reg;
  assign level   = level_reg;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed, table-driven bench for led_pwm_dimmer; PWM phase is tracked from reset release.
// Fade-specific ramp checks are compiled only when LED_PWM_FADE_EN is defined.
module tb_led_pwm_dimmer;
  localparam int WIDTH    = 8;
  localparam int PWM_BITS = 4;
  localparam int FADE_DIV = 16;
  localparam int MAX      = 15;
`ifdef LED_PWM_FADE_EN
  localparam int SETTLE = MAX * FADE_DIV + 40;
`else
  localparam int SETTLE = 0;
`endif

  typedef struct {
    logic [7:0] led;
    int         ups;
    int         downs;
    logic [3:0] exp_level;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [WIDTH-1:0]    led_in = '0;
  logic                bright_up = 1'b0;
  logic                bright_down = 1'b0;
  logic [WIDTH-1:0]    led_out;
  logic [PWM_BITS-1:0] level;

  int tests  = 0;
  int failed = 0;
  int edges  = 0;

  led_pwm_dimmer #(.WIDTH(WIDTH), .PWM_BITS(PWM_BITS), .FADE_DIV(FADE_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .led_in(led_in),
    .bright_up(bright_up),
    .bright_down(bright_down),
    .led_out(led_out),
    .level(level)
  );

  always #5 clk = ~clk;

  // Counting edges since release: after k edges led_out reflects cnt = (k-1) mod MAX.
  always @(posedge clk) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    tests++;
    if (val < lo || val > hi) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic up, input logic down, input int n);
    repeat (n) begin
      @(negedge clk);
      bright_up   = up;
      bright_down = down;
    end
    @(negedge clk);
    bright_up   = 1'b0;
    bright_down = 1'b0;
  endtask

  // Waits for a run of MAX consecutive samples of led_out[0] equal to want.
  task automatic measure_run(input logic want, output int t);
    int run;
    run = 0;
    t   = -1;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      if (led_out[0] == want) run++;
      else run = 0;
      if (run == MAX) begin
        t = c;
        break;
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    int bad;
    int phase;
    int t;
    int highs;
    logic [7:0] exp_out;

    vecs[0] = '{led: 8'hA5, ups: 7,  downs: 0,  exp_level: 4'd15};
    vecs[1] = '{led: 8'hA5, ups: 0,  downs: 20, exp_level: 4'd0};
    vecs[2] = '{led: 8'hFF, ups: 8,  downs: 0,  exp_level: 4'd8};
    vecs[3] = '{led: 8'h3C, ups: 0,  downs: 5,  exp_level: 4'd3};
    vecs[4] = '{led: 8'h5A, ups: 9,  downs: 0,  exp_level: 4'd12};
    vecs[5] = '{led: 8'h81, ups: 20, downs: 0,  exp_level: 4'd15};

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      led_in      = 8'($urandom);
      bright_up   = 1'($urandom);
      bright_down = 1'($urandom);
      check($sformatf("reset_led_out_%0d", i), 32'(led_out), 32'h00);
      check($sformatf("reset_level_%0d", i), 32'(level), 32'd8);
    end
    @(negedge clk);
    led_in      = '0;
    bright_up   = 1'b0;
    bright_down = 1'b0;
    rst         = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (led_out !== 8'h00) bad++;
    end
    check("release_dark_bad_cycles", 32'(bad), 32'd0);
    check("release_level", 32'(level), 32'd8);
    $display("[TB] reset and release done");

    for (int v = 0; v < 6; v++) begin
      led_in = vecs[v].led;
      if (vecs[v].ups > 0)   pulse(1'b1, 1'b0, vecs[v].ups);
      if (vecs[v].downs > 0) pulse(1'b0, 1'b1, vecs[v].downs);
      cycles(SETTLE);
      check($sformatf("vec%0d_level", v), 32'(level), 32'(vecs[v].exp_level));
      bad = 0;
      for (int c = 0; c < 2 * MAX; c++) begin
        @(negedge clk);
        phase   = (edges - 1) % MAX;
        exp_out = (phase < int'(vecs[v].exp_level)) ? vecs[v].led : 8'h00;
        if (led_out !== exp_out) bad++;
      end
      check($sformatf("vec%0d_pwm_bad_cycles", v), 32'(bad), 32'd0);
      $display("[TB] vec %0d led_in=0x%02h level=%0d bad_cycles=%0d", v, vecs[v].led, level, bad);
    end

    // Saturation and collisions.
    pulse(1'b1, 1'b0, 20);
    check("sat_up_level", 32'(level), 32'd15);
    pulse(1'b1, 1'b1, 1);
    check("collide_at_max", 32'(level), 32'd15);
    pulse(1'b0, 1'b1, 20);
    check("sat_down_level", 32'(level), 32'd0);
    pulse(1'b0, 1'b1, 1);
    check("down_at_zero", 32'(level), 32'd0);
    pulse(1'b1, 1'b1, 1);
    check("collide_at_zero", 32'(level), 32'd0);
    pulse(1'b1, 1'b0, 1);
    check("single_up_next_cycle", 32'(level), 32'd1);
    pulse(1'b1, 1'b0, 14);
    check("back_to_max", 32'(level), 32'd15);
    $display("[TB] saturation sequence done level=%0d", level);

`ifndef LED_PWM_FADE_EN
    // Two-cycle input-to-pin latency at steady-on level.
    led_in = 8'h00;
    cycles(3);
    check("latency_pre", 32'(led_out), 32'h00);
    led_in = 8'h3C;
    @(negedge clk);
    check("latency_edge1", 32'(led_out), 32'h00);
    @(negedge clk);
    check("latency_edge2", 32'(led_out), 32'h3C);
    $display("[TB] latency sequence done");
`endif

    // Asynchronous reset between clock edges.
    led_in = 8'hFF;
    cycles(SETTLE + 3);
    check("pre_async_reset_led_out", 32'(led_out), 32'hFF);
    #2 rst = 1'b0;
    #1;
    check("async_reset_led_out", 32'(led_out), 32'h00);
    check("async_reset_level", 32'(level), 32'd8);
    cycles(3);
    rst = 1'b1;
    $display("[TB] async reset sequence done");

`ifdef LED_PWM_FADE_EN
    pulse(1'b1, 1'b0, 7);
    led_in = 8'h00;
    cycles(SETTLE);
    led_in = 8'h01;
    measure_run(1'b1, t);
    check_range("fade_up_cycles", t, 220, 275);
    led_in = 8'h00;
    measure_run(1'b0, t);
    check_range("fade_down_cycles", t, 220, 275);
    led_in = 8'h01;
    cycles(100);
    #2 rst = 1'b0;
    #1;
    check("fade_reset_led_out", 32'(led_out), 32'h00);
    cycles(3);
    rst = 1'b1;
    cycles(20);
    highs = 0;
    for (int c = 0; c < MAX; c++) begin
      @(negedge clk);
      if (led_out[0]) highs++;
    end
    check_range("fade_restart_from_zero_highs", highs, 0, 3);
    $display("[TB] fade sequence done");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
